digital_timer_n: RTL and testbench

Parametrised multi-digit BCD timer: a programmable prescaler drives a DIGITS-wide decimal counter that counts up or down, with start/stop/clear/load control, and a one-shot `done` on down-count expiry. The counter is kept directly in BCD, so no binary-to-BCD stage is needed. Each digit is registered through an internal seven-segment encoder. It is the next-generation top-level timer for the board's HEX displays and replaces the fixed two-digit 0–99 counter chain.

---
 rtl/digital_timer_n.sv | 178 +++++++++++++++++
 tb/tb_digital_timer_n.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/digital_timer_n.sv
// Multi-digit BCD up/down timer with programmable prescaler and registered
// seven-segment outputs. Define DIGITAL_TIMER_BLANK_EN for leading-zero blanking.
module digital_timer_n #(
    parameter int CLK_DIV = 25,
    parameter int DIGITS  = 2
) (
    input  logic                  clk_50MHz,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_bcd,
    input  logic                  up_down,
    output logic                  run,
    output logic                  done,
    output logic                  wrap,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [8*DIGITS-1:0]   seg
);

    localparam int              BW     = 4 * DIGITS;
    localparam int              SW     = 8 * DIGITS;
    localparam logic [23:0]     PRE_TC = 24'(CLK_DIV - 1);
    localparam logic [BW-1:0]   ALL9   = {DIGITS{4'h9}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [23:0]    r_pre, w_pre_nxt;
    logic [BW-1:0]  r_bcd, w_bcd_nxt;
    logic           r_done, w_done_nxt;
    logic           r_wrap, w_wrap_nxt;
    logic [SW-1:0]  r_seg;

    logic [BW-1:0]  w_inc, w_dec, w_load_sat;
    logic           w_carry, w_borrow;
    logic           w_tick;

    function automatic logic [7:0] enc7(input logic [3:0] d);
        case (d)
            4'd0:    enc7 = 8'hC0;
            4'd1:    enc7 = 8'hF9;
            4'd2:    enc7 = 8'hA4;
            4'd3:    enc7 = 8'hB0;
            4'd4:    enc7 = 8'h99;
            4'd5:    enc7 = 8'h92;
            4'd6:    enc7 = 8'h82;
            4'd7:    enc7 = 8'hF8;
            4'd8:    enc7 = 8'h80;
            4'd9:    enc7 = 8'h90;
            default: enc7 = 8'hFF;
        endcase
    endfunction

    // Walk from the most significant digit down so blanking knows whether
    // everything above the current digit is zero.
    function automatic logic [SW-1:0] seg_of(input logic [BW-1:0] v);
        logic [SW-1:0] s;
`ifdef DIGITAL_TIMER_BLANK_EN
        logic hi_zero;
        hi_zero = 1'b1;
`endif
        s = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            s[8*i +: 8] = enc7(v[4*i +: 4]);
`ifdef DIGITAL_TIMER_BLANK_EN
            hi_zero = hi_zero & (v[4*i +: 4] == 4'd0);
            if (i != 0 && hi_zero) begin
                s[8*i +: 8] = 8'hFF;
            end
`endif
        end
        return s;
    endfunction

    always_comb begin
        w_inc      = r_bcd;
        w_dec      = r_bcd;
        w_load_sat = load_bcd;
        w_carry    = 1'b1;
        w_borrow   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry) begin
                if (r_bcd[4*i +: 4] == 4'd9) begin
                    w_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_inc[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
                    w_carry         = 1'b0;
                end
            end
            if (w_borrow) begin
                if (r_bcd[4*i +: 4] == 4'd0) begin
                    w_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_dec[4*i +: 4] = r_bcd[4*i +: 4] - 4'd1;
                    w_borrow        = 1'b0;
                end
            end
            if (load_bcd[4*i +: 4] > 4'd9) begin
                w_load_sat[4*i +: 4] = 4'd9;
            end
        end
    end

    assign w_tick = (r_state == S_RUN) && (r_pre == PRE_TC);

    // Strict priority: clear > load > stop > start > tick; only the winner acts.
    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre;
        w_bcd_nxt   = r_bcd;
        w_done_nxt  = 1'b0;
        w_wrap_nxt  = 1'b0;
        if (clear) begin
            w_bcd_nxt   = '0;
            w_pre_nxt   = '0;
            w_state_nxt = S_IDLE;
        end else if (load) begin
            w_bcd_nxt = w_load_sat;
            w_pre_nxt = '0;
        end else if (stop) begin
            w_pre_nxt   = '0;
            w_state_nxt = S_IDLE;
        end else if (start) begin
            w_pre_nxt = '0;
            if (r_state == S_IDLE && !(!up_down && r_bcd == '0)) begin
                w_state_nxt = S_RUN;
            end
        end else if (r_state == S_RUN) begin
            if (w_tick) begin
                w_pre_nxt = '0;
                if (up_down) begin
                    w_bcd_nxt  = w_inc;
                    w_wrap_nxt = (r_bcd == ALL9);
                end else begin
                    w_bcd_nxt = w_dec;
                    if (w_dec == '0) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end else begin
                w_pre_nxt = r_pre + 24'd1;
            end
        end else begin
            w_pre_nxt = '0;
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pre   <= '0;
            r_bcd   <= '0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
            r_seg   <= seg_of({BW{1'b0}});
        end else begin
            r_state <= w_state_nxt;
            r_pre   <= w_pre_nxt;
            r_bcd   <= w_bcd_nxt;
            r_done  <= w_done_nxt;
            r_wrap  <= w_wrap_nxt;
            r_seg   <= seg_of(r_bcd);
        end
    end

    assign run  = (r_state == S_RUN);
    assign done = r_done;
    assign wrap = r_wrap;
    assign bcd  = r_bcd;
    assign seg  = r_seg;

endmodule

// File: tb/tb_digital_timer_n.sv
// Directed bench for digital_timer_n (CLK_DIV=4, DIGITS=2); the three-digit
// blanking scenario is added when DIGITAL_TIMER_BLANK_EN is defined.
module tb_digital_timer_n;

    localparam int CLK_DIV = 4;
    localparam int DIGITS  = 2;

`ifdef DIGITAL_TIMER_BLANK_EN
    localparam logic [7:0]  EXP_HI0 = 8'hFF;
`else
    localparam logic [7:0]  EXP_HI0 = 8'hC0;
`endif
    localparam logic [15:0] SEG_RST = {EXP_HI0, 8'hC0};
    localparam logic [15:0] SEG_01  = {EXP_HI0, 8'hF9};

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        start   = 1'b0;
    logic        stop    = 1'b0;
    logic        clear   = 1'b0;
    logic        load    = 1'b0;
    logic [7:0]  load_bcd = 8'h00;
    logic        up_down = 1'b1;
    logic        run, done, wrap;
    logic [7:0]  bcd;
    logic [15:0] seg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] enc_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always #5 clk = ~clk;

    digital_timer_n #(.CLK_DIV(CLK_DIV), .DIGITS(DIGITS)) u_dut (
        .clk_50MHz (clk),
        .reset     (reset_n),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .load      (load),
        .load_bcd  (load_bcd),
        .up_down   (up_down),
        .run       (run),
        .done      (done),
        .wrap      (wrap),
        .bcd       (bcd),
        .seg       (seg)
    );

`ifdef DIGITAL_TIMER_BLANK_EN
    logic        load3     = 1'b0;
    logic [11:0] load_bcd3 = 12'h000;
    logic        run3, done3, wrap3;
    logic [11:0] bcd3;
    logic [23:0] seg3;

    digital_timer_n #(.CLK_DIV(CLK_DIV), .DIGITS(3)) u_dut3 (
        .clk_50MHz (clk),
        .reset     (reset_n),
        .start     (1'b0),
        .stop      (1'b0),
        .clear     (1'b0),
        .load      (load3),
        .load_bcd  (load_bcd3),
        .up_down   (1'b1),
        .run       (run3),
        .done      (done3),
        .wrap      (wrap3),
        .bcd       (bcd3),
        .seg       (seg3)
    );
`endif

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_bcd = v;
        step(1);
        load     = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        step(3);
        n_checks++; if (bcd !== 8'h00) begin n_fail++; $display("FAIL reset_bcd: got %h exp %h", bcd, 8'h00); end
        n_checks++; if (run !== 1'b0) begin n_fail++; $display("FAIL reset_run: got %b exp 0", run); end
        n_checks++; if (done !== 1'b0 || wrap !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: done %b wrap %b exp 0 0", done, wrap); end
        n_checks++; if (seg !== SEG_RST) begin n_fail++; $display("FAIL reset_seg: got %h exp %h", seg, SEG_RST); end
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic test_up_count();
        up_down = 1'b1;
        pulse_start();
        n_checks++; if (run !== 1'b1) begin n_fail++; $display("FAIL up_run: got %b exp 1", run); end
        step(3);
        n_checks++; if (bcd !== 8'h00) begin n_fail++; $display("FAIL up_early: got %h exp 00", bcd); end
        step(1);
        n_checks++; if (bcd !== 8'h01) begin n_fail++; $display("FAIL up_first: got %h exp 01", bcd); end
        n_checks++; if (seg !== SEG_RST) begin n_fail++; $display("FAIL up_seg_lag: got %h exp %h", seg, SEG_RST); end
        step(1);
        n_checks++; if (seg !== SEG_01) begin n_fail++; $display("FAIL up_seg_01: got %h exp %h", seg, SEG_01); end
        step(2);
        n_checks++; if (bcd !== 8'h01) begin n_fail++; $display("FAIL up_hold: got %h exp 01", bcd); end
        step(1);
        n_checks++; if (bcd !== 8'h02) begin n_fail++; $display("FAIL up_second: got %h exp 02", bcd); end
        pulse_clear();
        n_checks++; if (bcd !== 8'h00 || run !== 1'b0) begin n_fail++; $display("FAIL up_clear: bcd %h run %b exp 00 0", bcd, run); end
    endtask

    task automatic test_wrap();
        do_load(8'h98);
        n_checks++; if (bcd !== 8'h98 || run !== 1'b0) begin n_fail++; $display("FAIL wrap_load: bcd %h run %b exp 98 0", bcd, run); end
        up_down = 1'b1;
        pulse_start();
        step(4);
        n_checks++; if (bcd !== 8'h99 || wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_99: bcd %h wrap %b exp 99 0", bcd, wrap); end
        step(4);
        n_checks++; if (bcd !== 8'h00 || wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_00: bcd %h wrap %b exp 00 1", bcd, wrap); end
        n_checks++; if (run !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL wrap_run: run %b done %b exp 1 0", run, done); end
        step(1);
        n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_width: got %b exp 0", wrap); end
        pulse_clear();
    endtask

    task automatic test_down_expiry();
        logic [7:0] exp_v;
        do_load(8'h10);
        up_down = 1'b0;
        pulse_start();
        n_checks++; if (run !== 1'b1) begin n_fail++; $display("FAIL down_run: got %b exp 1", run); end
        for (int k = 1; k <= 10; k++) begin
            step(4);
            exp_v = {4'((10 - k) / 10), 4'((10 - k) % 10)};
            n_checks++; if (bcd !== exp_v) begin n_fail++; $display("FAIL down_step%0d: got %h exp %h", k, bcd, exp_v); end
            if (k < 10) begin
                n_checks++; if (done !== 1'b0 || run !== 1'b1) begin n_fail++; $display("FAIL down_mid%0d: done %b run %b exp 0 1", k, done, run); end
            end else begin
                n_checks++; if (done !== 1'b1 || run !== 1'b0) begin n_fail++; $display("FAIL down_done: done %b run %b exp 1 0", done, run); end
            end
        end
        step(1);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL down_done_width: got %b exp 0", done); end
        pulse_start();
        n_checks++; if (run !== 1'b0) begin n_fail++; $display("FAIL down_restart: run %b exp 0", run); end
        step(5);
        n_checks++; if (bcd !== 8'h00 || done !== 1'b0) begin n_fail++; $display("FAIL down_idle: bcd %h done %b exp 00 0", bcd, done); end
    endtask

    task automatic test_priority_pause();
        do_load(8'h37);
        up_down = 1'b1;
        pulse_start();
        n_checks++; if (run !== 1'b1 || bcd !== 8'h37) begin n_fail++; $display("FAIL prio_run37: run %b bcd %h exp 1 37", run, bcd); end
        clear    = 1'b1;
        load     = 1'b1;
        load_bcd = 8'h55;
        step(1);
        clear = 1'b0;
        load  = 1'b0;
        n_checks++; if (bcd !== 8'h00 || run !== 1'b0) begin n_fail++; $display("FAIL prio_clear_load: bcd %h run %b exp 00 0", bcd, run); end
        do_load(8'h55);
        pulse_start();
        step(5);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        n_checks++; if (bcd !== 8'h56 || run !== 1'b0) begin n_fail++; $display("FAIL pause_stop: bcd %h run %b exp 56 0", bcd, run); end
        step(10);
        n_checks++; if (bcd !== 8'h56) begin n_fail++; $display("FAIL pause_hold: got %h exp 56", bcd); end
        n_checks++; if (seg !== 16'h9282) begin n_fail++; $display("FAIL pause_seg: got %h exp 9282", seg); end
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        n_checks++; if (run !== 1'b0) begin n_fail++; $display("FAIL start_stop: run %b exp 0", run); end
        pulse_start();
        step(2);
        do_load(8'h20);
        n_checks++; if (bcd !== 8'h20 || run !== 1'b1) begin n_fail++; $display("FAIL load_run: bcd %h run %b exp 20 1", bcd, run); end
        step(3);
        n_checks++; if (bcd !== 8'h20) begin n_fail++; $display("FAIL load_run_hold: got %h exp 20", bcd); end
        step(1);
        n_checks++; if (bcd !== 8'h21) begin n_fail++; $display("FAIL load_run_next: got %h exp 21", bcd); end
        pulse_clear();
    endtask

    task automatic test_encoder();
        logic [15:0] exp_s;
        for (int d = 0; d < 10; d++) begin
            do_load({4'(d), 4'(d)});
            step(1);
            exp_s = {(d == 0) ? EXP_HI0 : enc_tab[d], enc_tab[d]};
            n_checks++; if (seg !== exp_s) begin n_fail++; $display("FAIL enc_%0d: got %h exp %h", d, seg, exp_s); end
        end
        pulse_clear();
    endtask

    task automatic test_saturation_reset();
        do_load(8'hFA);
        n_checks++; if (bcd !== 8'h99) begin n_fail++; $display("FAIL sat_FA: got %h exp 99", bcd); end
        step(1);
        n_checks++; if (seg !== 16'h9090) begin n_fail++; $display("FAIL sat_seg: got %h exp 9090", seg); end
        do_load(8'h3C);
        n_checks++; if (bcd !== 8'h39) begin n_fail++; $display("FAIL sat_3C: got %h exp 39", bcd); end
        do_load(8'hFA);
        up_down = 1'b0;
        pulse_start();
        step(2);
        #3 reset_n = 1'b0;
        #1;
        n_checks++; if (bcd !== 8'h00 || run !== 1'b0) begin n_fail++; $display("FAIL async_reset: bcd %h run %b exp 00 0", bcd, run); end
        n_checks++; if (seg !== SEG_RST) begin n_fail++; $display("FAIL async_reset_seg: got %h exp %h", seg, SEG_RST); end
        step(2);
        reset_n = 1'b1;
        up_down = 1'b1;
        step(1);
    endtask

`ifdef DIGITAL_TIMER_BLANK_EN
    task automatic test_blanking();
        load3     = 1'b1;
        load_bcd3 = 12'h007;
        step(1);
        load3     = 1'b0;
        step(1);
        n_checks++; if (seg3 !== 24'hFFFFF8) begin n_fail++; $display("FAIL blank_007: got %h exp FFFFF8", seg3); end
        load3     = 1'b1;
        load_bcd3 = 12'h100;
        step(1);
        load3     = 1'b0;
        step(1);
        n_checks++; if (seg3 !== 24'hF9C0C0) begin n_fail++; $display("FAIL blank_100: got %h exp F9C0C0", seg3); end
    endtask
`endif

    initial begin
        test_reset();
        test_up_count();
        test_wrap();
        test_down_expiry();
        test_priority_pause();
        test_encoder();
        test_saturation_reset();
`ifdef DIGITAL_TIMER_BLANK_EN
        test_blanking();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
